// File: rtl/management_bus_initiator.sv
// Parses a framed byte stream into 16-bit address register writes/reads and streams read data back.
// Writes strobe one cycle after their byte; reads prefetch one byte at a time and hold tx_data until tx_ready.
module management_bus_initiator (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        dropped
);

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, DRAIN
  } state_t;

  state_t      state;
  logic [14:0] addr;
  logic        rd_flag;
  logic [14:0] addr_inc;
  logic        restart;

  assign addr_inc = addr + 15'd1;

  // A new frame may only open once no responder read is left in flight.
  assign restart = frame_start && (state != DRAIN) &&
                   !(((state == RD_ISSUE) || (state == RD_WAIT)) && !rd_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      rd_flag  <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      dropped <= 1'b0;
      busy    <= 1'b1;
      if (restart) begin
        tx_valid <= 1'b0;
        if (rx_valid) begin
          rd_flag    <= rx_data[7];
          addr[14:8] <= rx_data[6:0];
          state      <= ADDR_LO;
        end else begin
          state <= ADDR_HI;
        end
      end else begin
        case (state)
          IDLE: begin
            busy    <= 1'b0;
            dropped <= rx_valid;
          end
          ADDR_HI: begin
            if (rx_valid) begin
              rd_flag    <= rx_data[7];
              addr[14:8] <= rx_data[6:0];
              state      <= ADDR_LO;
            end
            if (frame_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          ADDR_LO: begin
            if (frame_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (rx_valid) begin
              addr[7:0] <= rx_data;
              if (rd_flag) begin
                rd_en   <= 1'b1;
                rd_addr <= {1'b0, addr[14:8], rx_data};
                state   <= RD_ISSUE;
              end else begin
                state <= WRITE;
              end
            end
          end
          WRITE: begin
            if (rx_valid) begin
              wr_en   <= 1'b1;
              wr_addr <= {1'b0, addr};
              wr_data <= rx_data;
              addr    <= addr_inc;
            end
            if (frame_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          // rd_en is already on the bus in RD_ISSUE, so an abort here must drain too.
          RD_ISSUE, RD_WAIT: begin
            if (rd_valid && frame_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (rd_valid) begin
              tx_data  <= rd_data;
              tx_valid <= 1'b1;
              state    <= RD_HOLD;
            end else if (frame_end || frame_start) begin
              state   <= DRAIN;
              dropped <= frame_start && rx_valid;
            end else begin
              state <= RD_WAIT;
            end
          end
          RD_HOLD: begin
            if (frame_end) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end else if (tx_ready) begin
              tx_valid <= 1'b0;
              addr     <= addr_inc;
              rd_en    <= 1'b1;
              rd_addr  <= {1'b0, addr_inc};
              state    <= RD_ISSUE;
            end
          end
          DRAIN: begin
            dropped <= rx_valid;
            if (rd_valid) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_management_bus_initiator.sv
// Randomised and directed bench for management_bus_initiator with a transaction-level reference model.
module tb_management_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, frame_end, rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, dropped;

  management_bus_initiator dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Responder / PHY model state
  int          resp_delay = 3;
  int          rdy_mode = 0;
  bit          resp_flush = 1'b0;
  bit          fixed_mode = 1'b0;
  int          fixed_base = 0;
  int          resp_cnt = 0;
  int          outstanding = 0;
  int          overlap_cnt = 0;
  int          unstable_cnt = 0;
  int          drop_cnt = 0;
  logic [7:0]  resp_q[$];
  logic [7:0]  acc_q[$];
  logic [15:0] rda_q[$];
  logic [23:0] wr_q[$];
  logic [7:0]  tx_prev = 8'h00;
  logic        tv_prev = 1'b0;
  logic        acc_prev = 1'b0;

  always @(negedge clk) begin
    rd_valid = 1'b0;
    if (resp_flush) begin
      resp_cnt    = 0;
      outstanding = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = fixed_mode ? 8'(17 * (resp_q.size() - fixed_base + 1)) : 8'($urandom);
          resp_q.push_back(rd_data);
          outstanding--;
        end
      end
      if (rd_en === 1'b1) begin
        if (outstanding != 0) overlap_cnt++;
        outstanding++;
        rda_q.push_back(rd_addr);
        resp_cnt = resp_delay;
      end
    end
    case (rdy_mode)
      1:       tx_ready = ($urandom_range(0, 1) == 1);
      2:       tx_ready = 1'b0;
      default: tx_ready = 1'b1;
    endcase
    if (tx_valid === 1'b1 && tv_prev && !acc_prev && tx_data !== tx_prev) unstable_cnt++;
    if (tx_valid === 1'b1 && tx_ready) acc_q.push_back(tx_data);
    tv_prev  = (tx_valid === 1'b1);
    tx_prev  = tx_data;
    acc_prev = (tx_valid === 1'b1) && tx_ready;
    if (wr_en === 1'b1) wr_q.push_back({wr_addr, wr_data});
    if (dropped === 1'b1) drop_cnt++;
  end

  // One bus cycle: inputs are live for the next posedge; returns just after the following negedge.
  task automatic cyc_drive(input bit fs, input bit fe, input bit rv, input logic [7:0] d);
    frame_start = fs;
    frame_end   = fe;
    rx_valid    = rv;
    rx_data     = d;
    @(negedge clk); #1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_valid    = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 100; k++) begin
      if (busy === 1'b0) break;
      cyc_drive(0, 0, 0, 8'h00);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_timeout: busy=%b required 0", nm, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    tests++;
    if ({rd_en, wr_en, tx_valid, busy, dropped} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 00000", {rd_en, wr_en, tx_valid, busy, dropped});
    end
    tests++;
    if ({rd_addr, wr_addr} !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr: got %h required 00000000", {rd_addr, wr_addr});
    end
    tests++;
    if ({wr_data, tx_data} !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: got %h required 0000", {wr_data, tx_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_write_burst;
    int wbase = wr_q.size();
    cyc_drive(1, 0, 0, 8'h00);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL wb_busy: got %b required 1", busy); end
    cyc_drive(0, 0, 1, 8'h40);
    cyc_drive(0, 0, 1, 8'h00);
    tests++;
    if (wr_en !== 1'b0) begin fails++; $display("FAIL wb_hdr_no_write: wr_en=%b required 0", wr_en); end
    cyc_drive(0, 0, 1, 8'hAA);
    tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h4000, 8'hAA}) begin
      fails++;
      $display("FAIL wb_first: got %b/%h/%h required 1/4000/aa", wr_en, wr_addr, wr_data);
    end
    cyc_drive(0, 0, 1, 8'h55);
    tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h4001, 8'h55}) begin
      fails++;
      $display("FAIL wb_second: got %b/%h/%h required 1/4001/55", wr_en, wr_addr, wr_data);
    end
    cyc_drive(0, 1, 0, 8'h00);
    tests++;
    if ({wr_en, busy} !== 2'b00) begin
      fails++;
      $display("FAIL wb_end: wr_en/busy=%b required 00", {wr_en, busy});
    end
    tests++;
    if (wr_q.size() - wbase != 2) begin
      fails++;
      $display("FAIL wb_count: got %0d writes required 2", wr_q.size() - wbase);
    end
  endtask

  task automatic test_read_stall;
    int abase = acc_q.size();
    int rbase = rda_q.size();
    resp_delay = 3;
    rdy_mode   = 0;
    fixed_base = resp_q.size();
    fixed_mode = 1'b1;
    cyc_drive(1, 0, 0, 8'h00);
    cyc_drive(0, 0, 1, 8'h80);
    cyc_drive(0, 0, 1, 8'h04);
    tests++;
    if ({rd_en, rd_addr} !== {1'b1, 16'h0004}) begin
      fails++;
      $display("FAIL rs_rd0: got %b/%h required 1/0004", rd_en, rd_addr);
    end
    repeat (3) cyc_drive(0, 0, 0, 8'h00);
    tests++;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL rs_early_tx: tx_valid=%b required 0", tx_valid); end
    cyc_drive(0, 0, 0, 8'h00);
    tests++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h11}) begin
      fails++;
      $display("FAIL rs_tx0: got %b/%h required 1/11", tx_valid, tx_data);
    end
    cyc_drive(0, 0, 0, 8'h00);
    tests++;
    if ({rd_en, rd_addr, tx_valid} !== {1'b1, 16'h0005, 1'b0}) begin
      fails++;
      $display("FAIL rs_rd1: got %b/%h/%b required 1/0005/0", rd_en, rd_addr, tx_valid);
    end
    for (int k = 0; k < 50; k++) begin
      if (acc_q.size() - abase >= 2) break;
      cyc_drive(0, 0, 0, 8'h00);
    end
    cyc_drive(0, 1, 0, 8'h00);
    wait_idle("rs");
    fixed_mode = 1'b0;
    tests++;
    if (acc_q.size() - abase != 2 || acc_q[abase] !== 8'h11 || acc_q[abase+1] !== 8'h22) begin
      fails++;
      $display("FAIL rs_bytes: got %0d bytes first %h second %h required 2 bytes 11 22",
               acc_q.size() - abase, acc_q[abase], acc_q[abase+1]);
    end
    tests++;
    if (rda_q.size() - rbase != 2 || overlap_cnt != 0) begin
      fails++;
      $display("FAIL rs_reads: got %0d reads, %0d overlaps required 2 reads, 0 overlaps",
               rda_q.size() - rbase, overlap_cnt);
    end
  endtask

  task automatic test_wrap;
    cyc_drive(1, 0, 0, 8'h00);
    cyc_drive(0, 0, 1, 8'h7F);
    cyc_drive(0, 0, 1, 8'hFF);
    cyc_drive(0, 0, 1, 8'hA1);
    tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h7FFF, 8'hA1}) begin
      fails++;
      $display("FAIL wrap_top: got %b/%h/%h required 1/7fff/a1", wr_en, wr_addr, wr_data);
    end
    cyc_drive(0, 0, 1, 8'hB2);
    tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0000, 8'hB2}) begin
      fails++;
      $display("FAIL wrap_zero: got %b/%h/%h required 1/0000/b2", wr_en, wr_addr, wr_data);
    end
    cyc_drive(0, 1, 0, 8'h00);
  endtask

  task automatic test_abort_drain;
    int abase = acc_q.size();
    int rbase = rda_q.size();
    int dbase = drop_cnt;
    int tv_seen = 0;
    resp_delay = 10;
    rdy_mode   = 0;
    cyc_drive(1, 0, 0, 8'h00);
    cyc_drive(0, 0, 1, 8'h80);
    cyc_drive(0, 0, 1, 8'h00);
    tests++;
    if ({rd_en, rd_addr} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL ab_rd: got %b/%h required 1/0000", rd_en, rd_addr);
    end
    cyc_drive(0, 0, 0, 8'h00);
    cyc_drive(0, 1, 0, 8'h00);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL ab_drain_busy: busy=%b required 1", busy); end
    cyc_drive(1, 0, 0, 8'h00);
    cyc_drive(0, 0, 1, 8'hC3);
    tests++;
    if (dropped !== 1'b1) begin fails++; $display("FAIL ab_drop0: dropped=%b required 1", dropped); end
    cyc_drive(0, 0, 1, 8'h3C);
    tests++;
    if (dropped !== 1'b1) begin fails++; $display("FAIL ab_drop1: dropped=%b required 1", dropped); end
    for (int k = 0; k < 30; k++) begin
      if (busy === 1'b0) break;
      if (tx_valid !== 1'b0) tv_seen++;
      cyc_drive(0, 0, 0, 8'h00);
    end
    tests++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || tv_seen != 0) begin
      fails++;
      $display("FAIL ab_exit: busy=%b tx_valid=%b tx cycles=%0d required 0 0 0", busy, tx_valid, tv_seen);
    end
    tests++;
    if (drop_cnt - dbase != 2 || rda_q.size() - rbase != 1 || acc_q.size() != abase) begin
      fails++;
      $display("FAIL ab_counts: drops=%0d reads=%0d tx=%0d required 2 1 0",
               drop_cnt - dbase, rda_q.size() - rbase, acc_q.size() - abase);
    end
  endtask

  task automatic test_same_cycle;
    int wbase;
    cyc_drive(0, 0, 1, 8'hEE);
    tests++;
    if ({dropped, busy} !== 2'b10) begin
      fails++;
      $display("FAIL sc_idle_drop: dropped/busy=%b required 10", {dropped, busy});
    end
    wbase = wr_q.size();
    cyc_drive(1, 0, 1, 8'h00);
    cyc_drive(0, 0, 1, 8'h10);
    cyc_drive(0, 1, 1, 8'h5A);
    tests++;
    if ({wr_en, wr_addr, wr_data, busy} !== {1'b1, 16'h0010, 8'h5A, 1'b0}) begin
      fails++;
      $display("FAIL sc_last_write: got %b/%h/%h busy %b required 1/0010/5a busy 0",
               wr_en, wr_addr, wr_data, busy);
    end
    cyc_drive(0, 0, 0, 8'h00);
    tests++;
    if (wr_q.size() - wbase != 1) begin
      fails++;
      $display("FAIL sc_count: got %0d writes required 1", wr_q.size() - wbase);
    end
    cyc_drive(1, 0, 0, 8'h00);
    cyc_drive(0, 0, 1, 8'h01);
    cyc_drive(0, 0, 1, 8'h02);
    cyc_drive(0, 0, 1, 8'h33);
    cyc_drive(1, 1, 1, 8'h00);
    tests++;
    if ({wr_en, busy} !== 2'b01) begin
      fails++;
      $display("FAIL sc_restart: wr_en/busy=%b required 01", {wr_en, busy});
    end
    cyc_drive(0, 0, 1, 8'h20);
    cyc_drive(0, 0, 1, 8'h77);
    tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0020, 8'h77}) begin
      fails++;
      $display("FAIL sc_new_frame: got %b/%h/%h required 1/0020/77", wr_en, wr_addr, wr_data);
    end
    cyc_drive(0, 1, 0, 8'h00);
  endtask

  task automatic test_reset_mid_read;
    resp_delay = 2;
    rdy_mode   = 2;
    cyc_drive(1, 0, 0, 8'h00);
    cyc_drive(0, 0, 1, 8'h80);
    cyc_drive(0, 0, 1, 8'h33);
    for (int k = 0; k < 20; k++) begin
      if (tx_valid === 1'b1) break;
      cyc_drive(0, 0, 0, 8'h00);
    end
    tests++;
    if (tx_valid !== 1'b1) begin fails++; $display("FAIL rm_hold: tx_valid=%b required 1", tx_valid); end
    rst = 1'b1;
    resp_flush = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({rd_en, wr_en, tx_valid, busy, dropped, rd_addr, wr_addr, wr_data, tx_data} !== 53'h0) begin
      fails++;
      $display("FAIL rm_outputs: got %h required 0",
               {rd_en, wr_en, tx_valid, busy, dropped, rd_addr, wr_addr, wr_data, tx_data});
    end
    rst = 1'b0;
    cyc_drive(0, 0, 0, 8'h00);
    resp_flush = 1'b0;
    rdy_mode   = 0;
    cyc_drive(1, 0, 1, 8'h00);
    cyc_drive(0, 0, 1, 8'h05);
    cyc_drive(0, 1, 1, 8'h99);
    tests++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0005, 8'h99}) begin
      fails++;
      $display("FAIL rm_after: got %b/%h/%h required 1/0005/99", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_random;
    for (int f = 0; f < 16; f++) begin
      bit          is_rd = ($urandom_range(0, 1) == 1);
      logic [14:0] base_a = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFE + $urandom_range(0, 1))
                                                         : 15'($urandom);
      int          len = $urandom_range(1, 4);
      logic [7:0]  hi = {is_rd, base_a[14:8]};
      logic [7:0]  d[4];
      int          wbase = wr_q.size();
      int          abase = acc_q.size();
      int          rbase = rda_q.size();
      int          qbase = resp_q.size();
      int          dbase = drop_cnt;
      bit          together = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if (is_rd) begin
        resp_delay = $urandom_range(1, 4);
        rdy_mode   = 1;
      end
      if ($urandom_range(0, 1) == 1) cyc_drive(1, 0, 1, hi);
      else begin
        cyc_drive(1, 0, 0, 8'h00);
        cyc_drive(0, 0, 1, hi);
      end
      cyc_drive(0, 0, 1, base_a[7:0]);
      if (!is_rd) begin
        for (int i = 0; i < len; i++) begin
          repeat ($urandom_range(0, 2)) cyc_drive(0, 0, 0, 8'h00);
          cyc_drive(0, together && (i == len - 1), 1, d[i]);
        end
        if (!together) cyc_drive(0, 1, 0, 8'h00);
        wait_idle("rnd_wr");
        tests++;
        if (wr_q.size() - wbase != len) begin
          fails++;
          $display("FAIL rnd_wr_count frame %0d: got %0d required %0d", f, wr_q.size() - wbase, len);
        end
        for (int i = 0; i < len && i < wr_q.size() - wbase; i++) begin
          logic [14:0] a = base_a + 15'(i);
          tests++;
          if (wr_q[wbase+i] !== {1'b0, a, d[i]}) begin
            fails++;
            $display("FAIL rnd_wr frame %0d beat %0d: got %h required %h", f, i, wr_q[wbase+i], {1'b0, a, d[i]});
          end
        end
      end else begin
        for (int k = 0; k < 300; k++) begin
          if (acc_q.size() - abase >= len) break;
          cyc_drive(0, 0, $urandom_range(0, 1) == 1, 8'($urandom));
        end
        cyc_drive(0, 1, 0, 8'h00);
        rdy_mode = 0;
        wait_idle("rnd_rd");
        tests++;
        if (acc_q.size() - abase != len || rda_q.size() - rbase != len || drop_cnt != dbase) begin
          fails++;
          $display("FAIL rnd_rd_count frame %0d: tx=%0d reads=%0d drops=%0d required %0d %0d 0",
                   f, acc_q.size() - abase, rda_q.size() - rbase, drop_cnt - dbase, len, len);
        end
        for (int i = 0; i < len && i < acc_q.size() - abase && i < rda_q.size() - rbase; i++) begin
          logic [14:0] a = base_a + 15'(i);
          tests++;
          if (acc_q[abase+i] !== resp_q[qbase+i] || rda_q[rbase+i] !== {1'b0, a}) begin
            fails++;
            $display("FAIL rnd_rd frame %0d beat %0d: data %h addr %h required data %h addr %h",
                     f, i, acc_q[abase+i], rda_q[rbase+i], resp_q[qbase+i], {1'b0, a});
          end
        end
      end
    end
    tests++;
    if (overlap_cnt != 0 || unstable_cnt != 0) begin
      fails++;
      $display("FAIL rnd_protocol: overlapping reads %0d, unstable tx_data %0d required 0 0",
               overlap_cnt, unstable_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    @(negedge clk); #1;
    test_reset;
    test_write_burst;
    test_read_stall;
    test_wrap;
    test_abort_drain;
    test_same_cycle;
    test_reset_mid_read;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
